// File: rtl/rv_branch_ctrl_pkg.sv
// Shared constants and helpers for the rv32i branch-prediction / redirect controller.
package rv_branch_ctrl_pkg;

    // Default BHT index width: 16 entries indexed by pc[5:2].
    localparam int unsigned BHT_IDX_W_DEF = 4;

    // Reset value of every BHT entry: weakly not-taken.
    localparam logic [1:0] BHT_RESET_VAL = 2'b01;

    // EX-stage instruction class. Any value with bit 1 set is a jump (jal/jalr).
    typedef enum logic [1:0] {
        ClsOther  = 2'b00,
        ClsBranch = 2'b01,
        ClsJal    = 2'b10,
        ClsJalr   = 2'b11
    } br_jp_cls_e;

    // Two-bit saturating counter step.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rv_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one clocked update port.
module rv_bht
    import rv_branch_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = BHT_IDX_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [1:0] ctr_q [ENTRIES];

    // No bypass: a same-index update in this cycle is seen by the read next cycle.
    assign o_rd_ctr = ctr_q[i_rd_idx];

    // Counter array: reset to weakly not-taken, saturating step on resolved branches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_RESET_VAL;
            end
        end else if (i_upd_en) begin
            ctr_q[i_upd_idx] <= bht_next(ctr_q[i_upd_idx], i_upd_taken);
        end
    end

endmodule

// File: rtl/rv_branch_ctrl.sv
// Branch prediction and redirect controller: ID-stage BHT prediction with early
// redirect, EX-stage resolution with flush/redirect, and performance counters.
module rv_branch_ctrl
    import rv_branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_IDX_W = BHT_IDX_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_brctl_stall,
    input  logic            i_brctl_is_br_id,
    input  logic [XLEN-1:0] i_brctl_pc_id,
    input  logic [XLEN-1:0] i_brctl_target_id,
    input  logic [1:0]      i_brctl_is_br_jp_ex,
    input  logic            i_brctl_take_ex,
    input  logic [XLEN-1:0] i_brctl_pc_ex,
    input  logic [XLEN-1:0] i_brctl_target_ex,
    output logic            o_brctl_pred_id,
    output logic            o_brctl_flush_ifid,
    output logic            o_brctl_flush_idex,
    output logic            o_brctl_redirect,
    output logic [XLEN-1:0] o_brctl_redirect_pc,
    output logic [31:0]     o_brctl_br_cnt,
    output logic [31:0]     o_brctl_mispred_cnt
);

    logic [BHT_IDX_W-1:0] idx_id;
    logic [BHT_IDX_W-1:0] idx_ex;
    logic [1:0]           bht_ctr;
    logic                 ex_br;
    logic                 ex_jp;
    logic                 mispred;
    logic                 ex_redirect;
    logic                 id_redirect;
    logic                 pred_ex_q;
    logic                 pred_ex_d;
    logic [31:0]          br_cnt_q;
    logic [31:0]          mispred_cnt_q;
    logic                 unused_bits;

    assign idx_id = i_brctl_pc_id[BHT_IDX_W+1:2];
    assign idx_ex = i_brctl_pc_ex[BHT_IDX_W+1:2];

    // PC bits outside the index and the counter LSB do not affect the controller.
    assign unused_bits = ^{i_brctl_pc_id[XLEN-1:BHT_IDX_W+2], i_brctl_pc_id[1:0], bht_ctr[0]};

    rv_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (idx_id),
        .o_rd_ctr    (bht_ctr),
        .i_upd_en    (ex_br),
        .i_upd_idx   (idx_ex),
        .i_upd_taken (i_brctl_take_ex)
    );

    assign o_brctl_pred_id = bht_ctr[1];

    // EX resolution; EX is trusted to present ClsOther when bubbled/flushed.
    always_comb begin
        ex_br       = (br_jp_cls_e'(i_brctl_is_br_jp_ex) == ClsBranch);
        ex_jp       = i_brctl_is_br_jp_ex[1];
        mispred     = ex_br && (i_brctl_take_ex != pred_ex_q);
        ex_redirect = ex_jp || mispred;
        id_redirect = i_brctl_is_br_id && o_brctl_pred_id && !i_brctl_stall && !ex_redirect;
    end

    // Flush/redirect outputs; EX redirect wins over the ID early redirect.
    always_comb begin
        o_brctl_flush_ifid  = 1'b0;
        o_brctl_flush_idex  = 1'b0;
        o_brctl_redirect    = 1'b0;
        o_brctl_redirect_pc = '0;
        if (ex_redirect) begin
            o_brctl_flush_ifid = 1'b1;
            o_brctl_flush_idex = 1'b1;
            o_brctl_redirect   = 1'b1;
            if (ex_jp || i_brctl_take_ex) begin
                o_brctl_redirect_pc = i_brctl_target_ex;
            end else begin
                o_brctl_redirect_pc = i_brctl_pc_ex + XLEN'(4);
            end
        end else if (id_redirect) begin
            o_brctl_flush_ifid  = 1'b1;
            o_brctl_redirect    = 1'b1;
            o_brctl_redirect_pc = i_brctl_target_id;
        end
    end

    // A prediction only follows the branch into EX when it actually leaves ID unflushed.
    always_comb begin
        pred_ex_d = 1'b0;
        if (!ex_redirect && !i_brctl_stall) begin
            pred_ex_d = i_brctl_is_br_id && o_brctl_pred_id;
        end
    end

    // Prediction pipeline register and wrapping performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pred_ex_q     <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pred_ex_q <= pred_ex_d;
            if (ex_br) br_cnt_q <= br_cnt_q + 32'd1;
            if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign o_brctl_br_cnt      = br_cnt_q;
    assign o_brctl_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_rv_branch_ctrl.sv
// Directed, table-driven bench for rv_branch_ctrl. Each table row is one clock
// cycle: inputs are driven after the falling edge and outputs checked before
// the next rising edge, so counters show the state left by earlier rows.
module tb_rv_branch_ctrl;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            is_br_id;
    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] target_id;
    logic [1:0]      is_br_jp_ex;
    logic            take_ex;
    logic [XLEN-1:0] pc_ex;
    logic [XLEN-1:0] target_ex;
    logic            pred_id;
    logic            flush_ifid;
    logic            flush_idex;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     br_cnt;
    logic [31:0]     mispred_cnt;

    int checks   = 0;
    int failures = 0;

    rv_branch_ctrl #(
        .XLEN      (XLEN),
        .BHT_IDX_W (4)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_brctl_stall       (stall),
        .i_brctl_is_br_id    (is_br_id),
        .i_brctl_pc_id       (pc_id),
        .i_brctl_target_id   (target_id),
        .i_brctl_is_br_jp_ex (is_br_jp_ex),
        .i_brctl_take_ex     (take_ex),
        .i_brctl_pc_ex       (pc_ex),
        .i_brctl_target_ex   (target_ex),
        .o_brctl_pred_id     (pred_id),
        .o_brctl_flush_ifid  (flush_ifid),
        .o_brctl_flush_idex  (flush_idex),
        .o_brctl_redirect    (redirect),
        .o_brctl_redirect_pc (redirect_pc),
        .o_brctl_br_cnt      (br_cnt),
        .o_brctl_mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        is_br_id;
        logic [31:0] pc_id;
        logic [31:0] target_id;
        logic [1:0]  cls;
        logic        take;
        logic [31:0] pc_ex;
        logic [31:0] target_ex;
        logic        e_pred;
        logic        e_fifid;
        logic        e_fidex;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic [31:0] e_br;
        logic [31:0] e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs, input logic st, input logic ib, input logic [31:0] pi,
        input logic [31:0] ti, input logic [1:0] cl, input logic tk, input logic [31:0] pe,
        input logic [31:0] te, input logic ep, input logic ef, input logic ee,
        input logic er, input logic [31:0] erp, input logic [31:0] eb, input logic [31:0] em);
        vec_t v;
        v.rst = rs; v.stall = st; v.is_br_id = ib; v.pc_id = pi; v.target_id = ti;
        v.cls = cl; v.take = tk; v.pc_ex = pe; v.target_ex = te;
        v.e_pred = ep; v.e_fifid = ef; v.e_fidex = ee; v.e_redir = er; v.e_rpc = erp;
        v.e_br = eb; v.e_mis = em;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, name, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 1'b0; is_br_id = 1'b0; pc_id = '0; target_id = '0;
        is_br_jp_ex = 2'b00; take_ex = 1'b0; pc_ex = '0; target_ex = '0;
    endtask

    task automatic apply_row(input int r, input vec_t v);
        @(negedge clk);
        rst = v.rst; stall = v.stall; is_br_id = v.is_br_id; pc_id = v.pc_id;
        target_id = v.target_id; is_br_jp_ex = v.cls; take_ex = v.take;
        pc_ex = v.pc_ex; target_ex = v.target_ex;
        #1;
        check("pred_id", r, {31'd0, pred_id}, {31'd0, v.e_pred});
        check("flush_ifid", r, {31'd0, flush_ifid}, {31'd0, v.e_fifid});
        check("flush_idex", r, {31'd0, flush_idex}, {31'd0, v.e_fidex});
        check("redirect", r, {31'd0, redirect}, {31'd0, v.e_redir});
        if (v.e_redir) check("redirect_pc", r, redirect_pc, v.e_rpc);
        check("br_cnt", r, br_cnt, v.e_br);
        check("mispred_cnt", r, mispred_cnt, v.e_mis);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        //            rst st ib pc_id     tgt_id    cls    tk pc_ex     tgt_ex    pred fi fe rd rpc       br  mis
        // 1: reset state, branch in ID predicted not-taken
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h180, 2'b00, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   0,  0));
        // 2: two taken resolutions with pred_ex=0, then predicted-taken ID redirect
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   2'b01, 1, 32'h100, 32'h180, 0, 1, 1, 1, 32'h180, 0,  0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   2'b01, 1, 32'h100, 32'h180, 1, 1, 1, 1, 32'h180, 1,  1));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h180, 2'b00, 0, 32'h0,   32'h0,   1, 1, 0, 1, 32'h180, 2,  2));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   2'b01, 1, 32'h100, 32'h180, 1, 0, 0, 0, 32'h0,   2,  2));
        // 3: counter 11 predicts taken, resolves not-taken -> pc+4; read is pre-update
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h180, 2'b00, 0, 32'h0,   32'h0,   1, 1, 0, 1, 32'h180, 3,  2));
        vecs.push_back(mk(0, 0, 0, 32'h100, 32'h0,   2'b01, 0, 32'h100, 32'h180, 1, 1, 1, 1, 32'h104, 3,  2));
        // entry is now 10 (still predicts taken); one more not-taken drops it to 01
        vecs.push_back(mk(0, 0, 0, 32'h100, 32'h0,   2'b01, 0, 32'h100, 32'h180, 1, 0, 0, 0, 32'h0,   4,  3));
        vecs.push_back(mk(0, 0, 0, 32'h100, 32'h0,   2'b01, 1, 32'h104, 32'h300, 0, 1, 1, 1, 32'h300, 5,  3));
        // 4: EX mispredict and predicted-taken ID branch in the same cycle
        vecs.push_back(mk(0, 0, 1, 32'h104, 32'h300, 2'b01, 1, 32'h200, 32'h240, 1, 1, 1, 1, 32'h240, 6,  4));
        // pred_ex was cleared: not-taken resolution is not a mispredict
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   2'b01, 0, 32'h104, 32'h300, 1, 0, 0, 0, 32'h0,   7,  5));
        // 5: two stall cycles hold off the ID redirect and clear pred_ex
        vecs.push_back(mk(0, 1, 1, 32'h100, 32'h180, 2'b00, 0, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   8,  5));
        vecs.push_back(mk(0, 1, 1, 32'h100, 32'h180, 2'b01, 0, 32'h104, 32'h300, 1, 0, 0, 0, 32'h0,   8,  5));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h180, 2'b00, 0, 32'h0,   32'h0,   1, 1, 0, 1, 32'h180, 9,  5));
        // pred_ex=1 now: not-taken resolution mispredicts to pc+4
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   2'b01, 0, 32'h100, 32'h180, 1, 1, 1, 1, 32'h104, 9,  5));
        // 6: jalr redirects, leaves BHT and counters alone
        vecs.push_back(mk(0, 0, 0, 32'h100, 32'h0,   2'b11, 1, 32'h100, 32'h400, 0, 1, 1, 1, 32'h400, 10, 6));
        vecs.push_back(mk(0, 0, 0, 32'h100, 32'h0,   2'b00, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   10, 6));
        vecs.push_back(mk(0, 0, 0, 32'h100, 32'h0,   2'b01, 1, 32'h108, 32'h500, 0, 1, 1, 1, 32'h500, 10, 6));
        // reset asserted while a predicted-taken branch leaves ID
        vecs.push_back(mk(1, 0, 1, 32'h108, 32'h500, 2'b00, 0, 32'h0,   32'h0,   1, 1, 0, 1, 32'h500, 11, 7));
        // after reset: entry back to 01, counters 0, pred_ex cleared
        vecs.push_back(mk(0, 0, 0, 32'h108, 32'h0,   2'b01, 0, 32'h10c, 32'h600, 0, 0, 0, 0, 32'h0,   0,  0));
        vecs.push_back(mk(0, 0, 0, 32'h10c, 32'h0,   2'b01, 1, 32'h108, 32'h500, 0, 1, 1, 1, 32'h500, 1,  0));
        vecs.push_back(mk(0, 0, 0, 32'h108, 32'h0,   2'b00, 0, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   2,  1));
        // jal in EX beats predicted-taken ID branch; jal does not train its index
        vecs.push_back(mk(0, 0, 1, 32'h108, 32'h500, 2'b10, 0, 32'h108, 32'h800, 1, 1, 1, 1, 32'h800, 2,  1));
        vecs.push_back(mk(0, 0, 0, 32'h108, 32'h0,   2'b01, 0, 32'h10c, 32'h600, 1, 0, 0, 0, 32'h0,   2,  1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   2'b00, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0,   3,  1));

        // Initial reset, then run the table.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < vecs.size(); r++) begin
            apply_row(r, vecs[r]);
        end

        // Hand-written: mid-run reset clears a trained entry and the counters.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pc_id = 32'h108;
        #1;
        check("post_reset_pred", 100, {31'd0, pred_id}, 32'd0);
        check("post_reset_br_cnt", 100, br_cnt, 32'd0);
        check("post_reset_mis_cnt", 100, mispred_cnt, 32'd0);
        check("post_reset_redirect", 100, {31'd0, redirect}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
